ram_scan_reader: RTL and testbench

//   Read-side initiator for the 64x8 single-port RAM used as the LCD frame/char buffer.
//   On start, issues sequential reads (ce=1, we=0) from base_addr for len+1 bytes.

---
 rtl/ram_scan_reader.sv | 153 +++++++++++++++
 tb/tb_ram_scan_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Sequential read initiator for the 64x8 LCD frame/char buffer RAM; streams bytes out over valid/ready.
// Define RAM_SCAN_LOOP_EN for continuous refresh: the scan restarts from the latched base until abort.
module ram_scan_reader #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] ram_addr,
    output logic          ram_ce,
    output logic          ram_we,
    input  logic [DW-1:0] ram_data_r,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | RAM read strobe for address r_cur
    // CAPT   | RAM read data available, captured into the output register
    // HOLD   | byte presented, waiting for the consumer to accept
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_done;
    logic          w_accept;
`ifdef RAM_SCAN_LOOP_EN
    logic [AW-1:0] r_base;
`endif

    assign w_accept = (r_state == S_HOLD) && r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_ISSUE;
                S_ISSUE: w_next = S_CAPT;
                S_CAPT:  w_next = S_HOLD;
                S_HOLD: begin
                    if (w_accept) begin
`ifdef RAM_SCAN_LOOP_EN
                        w_next = S_ISSUE;
`else
                        w_next = r_last ? S_IDLE : S_ISSUE;
`endif
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath registers: address/count tracking and the held output byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RAM_SCAN_LOOP_EN
            r_base  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_len <= len;
                            r_cur <= base_addr;
                            r_cnt <= '0;
`ifdef RAM_SCAN_LOOP_EN
                            r_base <= base_addr;
`endif
                        end
                    end
                    S_CAPT: begin
                        r_data  <= ram_data_r;
                        r_valid <= 1'b1;
                        r_last  <= (r_cnt == r_len);
                    end
                    S_HOLD: begin
                        if (w_accept) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (r_last) begin
                                r_done <= 1'b1;
`ifdef RAM_SCAN_LOOP_EN
                                r_cur  <= r_base;
                                r_cnt  <= '0;
`endif
                            end else begin
                                // Modulo-2**AW wrap is intentional.
                                r_cur <= r_cur + 1'b1;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ram_ce    = (r_state == S_ISSUE);
        ram_we    = 1'b0;
        ram_addr  = r_cur;
        busy      = (r_state != S_IDLE);
        out_data  = r_data;
        out_valid = r_valid;
        out_last  = r_last;
        done      = r_done;
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: stimulus pushes expected bytes/addresses, a negedge monitor checks them.
module tb_ram_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] base_addr = '0;
    logic [5:0] len = '0;
    logic [5:0] ram_addr;
    logic       ram_ce, ram_we;
    logic [7:0] ram_data_r = '0;
    logic [7:0] out_data;
    logic       out_valid, out_last, busy, done;

    ram_scan_reader #(.AW(6), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .ram_addr(ram_addr),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_data_r(ram_data_r),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    always @(posedge clk) if (ram_ce && !ram_we) ram_data_r <= mem[ram_addr];

    typedef struct { logic [7:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    int   addr_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready_en = 0;
    bit   done_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor
    always @(negedge clk) begin
        bit   done_next;
        exp_t e;
        done_next = 0;
        if (rst_n) begin
            check("done", done, done_exp);
            check("ram_we", ram_we, 0);
            if (ram_ce) begin
                if (addr_q.size() == 0) fail_now("unexpected ram_ce");
                else check("ram_addr", ram_addr, addr_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected byte");
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                    if (e.l && !abort) done_next = 1;
                end
            end
        end
        done_exp = done_next;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic push_frame(input int b, input int l);
        exp_t e;
        for (int i = 0; i <= l; i++) begin
            e.d = mem[(b + i) % 64];
            e.l = (i == l);
            exp_q.push_back(e);
            addr_q.push_back((b + i) % 64);
        end
    endtask

    // Returns in cycle 1 (the ISSUE cycle) of the scan.
    task automatic do_start(input int b, input int l);
        @(posedge clk);
        #1;
        base_addr = 6'(b);
        len = 6'(l);
        start = 1;
        push_frame(b, l);
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic flush();
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
        end
        fail_now({name, " timeout"});
        flush();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) return;
            @(posedge clk);
            #1;
        end
        fail_now({name, " valid timeout"});
    endtask

    initial begin
        logic [7:0] held;
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ram_ce", ram_ce, 0);
        check("rst ram_addr", ram_addr, 0);
        rst_n = 1;

        // T1: basic scan, latency
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
        out_ready = 1;
        do_start(0, 3);
        check("T1 ce cycle1", ram_ce, 1);
        @(posedge clk); #1;
        check("T1 valid cycle2", out_valid, 0);
        @(posedge clk); #1;
        check("T1 valid cycle3", out_valid, 1);
        wait_idle("T1");

        // T2: address wrap
        mem[62] = 8'h11; mem[63] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        do_start(62, 3);
        wait_idle("T2");

        // T3: back-pressure hold
        out_ready = 0;
        do_start(20, 1);
        wait_valid("T3");
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("T3 hold valid", out_valid, 1);
            check("T3 hold data", out_data, held);
            check("T3 hold ce", ram_ce, 0);
        end
        out_ready = 1;
        wait_idle("T3");

        // T4: start while busy ignored, then abort in HOLD
        do_start(30, 7);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 6'd50; len = 6'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        out_ready = 0;
        wait_valid("T4");
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("T4 abort valid", out_valid, 0);
        check("T4 abort last", out_last, 0);
        check("T4 abort busy", busy, 0);
        check("T4 abort ce", ram_ce, 0);
        flush();
        repeat (2) @(posedge clk); #1;
        check("T4 no done", done, 0);

        // start and abort together in IDLE
        start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        check("start+abort busy", busy, 0);
        repeat (2) @(posedge clk); #1;
        check("start+abort idle", busy, 0);

        // T5: reset during CAPT
        out_ready = 1;
        do_start(40, 5);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("T5 out_valid", out_valid, 0);
        check("T5 out_data", out_data, 0);
        check("T5 out_last", out_last, 0);
        check("T5 busy", busy, 0);
        check("T5 done", done, 0);
        check("T5 ram_ce", ram_ce, 0);
        check("T5 ram_addr", ram_addr, 0);
        flush();
        @(posedge clk); #1;
        rst_n = 1;
        mem[5] = 8'h5A;
        do_start(5, 0);
        wait_idle("T5");

        // Randomized scans with random back-pressure
        rand_ready_en = 1;
        for (int n = 0; n < 14; n++) begin
            for (int k = 0; k < 8; k++) mem[$urandom_range(0, 63)] = 8'($urandom);
            do_start($urandom_range(0, 63), (n == 13) ? 63 : $urandom_range(0, 9));
            wait_idle("rand");
        end
        rand_ready_en = 0;
        @(posedge clk); #1;
        out_ready = 1;

`ifdef RAM_SCAN_LOOP_EN
        // T6: continuous refresh until abort
        mem[10] = 8'hC1; mem[11] = 8'hC2;
        do_start(10, 1);
        for (int f = 0; f < 4; f++) push_frame(10, 1);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() <= 3) break;
            @(posedge clk); #1;
        end
        check("T6 looping busy", busy, 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        flush();
        check("T6 abort busy", busy, 0);
        check("T6 abort valid", out_valid, 0);
        repeat (3) @(posedge clk); #1;
        check("T6 stays idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
